// File: rtl/bp_pkg.sv
// bp_pkg: 2-bit counter encodings, init value, FSM states and training rule shared by branch predictors.
package bp_pkg;
    typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b11, ST = 2'b10} cnt_e;
    typedef enum logic {S_INIT, S_RUN} state_e;
    localparam logic [1:0] INIT_VAL = WT;
    function automatic logic [1:0] train(input logic [1:0] c, input logic t);
        return t ? (c == SNT ? WNT : c == WNT ? WT : ST)
                 : (c == ST ? WT : c == WT ? WNT : SNT);
    endfunction
endpackage

// File: rtl/pht_update_ctrl_if.sv
// pht_update_ctrl_if: update request handshake plus the PHT update read/write port.
interface pht_update_ctrl_if #(parameter int PHT_DEPTH = 14);
    logic                 upd_valid;
    logic [PHT_DEPTH-1:0] upd_index;
    logic                 upd_taken;
    logic                 upd_ready;
    logic [PHT_DEPTH-1:0] pht_raddr;
    logic [1:0]           pht_rdata;
    logic                 pht_we;
    logic [PHT_DEPTH-1:0] pht_waddr;
    logic [1:0]           pht_wdata;
    modport master (output upd_valid, upd_index, upd_taken, pht_rdata,
                    input upd_ready, pht_raddr, pht_we, pht_waddr, pht_wdata);
    modport slave (input upd_valid, upd_index, upd_taken, pht_rdata,
                   output upd_ready, pht_raddr, pht_we, pht_waddr, pht_wdata);
endinterface

// File: rtl/bp_upd_fifo.sv
// bp_upd_fifo: power-of-2 FIFO with full/empty flags, synchronous flush and simultaneous push/pop.
module bp_upd_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wp_q, rp_q;
    assign empty = wp_q == rp_q;
    assign full  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    assign dout  = mem_q[rp_q[AW-1:0]];
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            wp_q <= '0;
            rp_q <= '0;
        end else if (flush) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            if (push && !full) wp_q <= wp_q + (AW+1)'(1);
            if (pop && !empty) rp_q <= rp_q + (AW+1)'(1);
        end
    always_ff @(posedge clk)
        if (push && !full) mem_q[wp_q[AW-1:0]] <= din;
endmodule

// File: rtl/pht_update_ctrl.sv
// pht_update_ctrl: PHT init walk plus queued read-modify-write training with read-after-write forwarding.
module pht_update_ctrl
    import bp_pkg::*;
#(
    parameter int PHT_DEPTH  = 14,
    parameter int FIFO_DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    pht_update_ctrl_if.slave bus,
    input  logic init_req,
    output logic init_busy,
    output logic ovf_err
);
    state_e               state_q;
    logic [PHT_DEPTH-1:0] walk_q, w_idx_q, fwd_idx_q, h_idx;
    logic                 w_valid_q, w_taken_q, fwd_valid_q, ovf_q, h_taken;
    logic [1:0]           fwd_data_q, base, upd_val;
    logic                 run, push, pop, full, empty;
    assign run       = state_q == S_RUN;
    assign init_busy = ~run;
    assign ovf_err   = ovf_q;
    assign push      = bus.upd_valid & bus.upd_ready;
    assign pop       = run & ~empty;
    bp_upd_fifo #(.W(PHT_DEPTH + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk), .rst(rst), .flush(init_req), .push(push), .pop(pop),
        .din({bus.upd_index, bus.upd_taken}), .dout({h_idx, h_taken}),
        .full(full), .empty(empty)
    );
    // the memory port returns the pre-write value when W and R hit the same entry
    assign base          = (fwd_valid_q && fwd_idx_q == w_idx_q) ? fwd_data_q : bus.pht_rdata;
    assign upd_val       = train(base, w_taken_q);
    assign bus.upd_ready = ~full & run;
    assign bus.pht_raddr = h_idx;
    assign bus.pht_we    = rst & (~run | w_valid_q);
    assign bus.pht_waddr = run ? w_idx_q : walk_q;
    assign bus.pht_wdata = run ? upd_val : INIT_VAL;
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state_q     <= S_INIT;
            walk_q      <= '0;
            w_valid_q   <= 1'b0;
            w_idx_q     <= '0;
            w_taken_q   <= 1'b0;
            fwd_valid_q <= 1'b0;
            fwd_idx_q   <= '0;
            fwd_data_q  <= '0;
            ovf_q       <= 1'b0;
        end else begin
            ovf_q <= ovf_q | (bus.upd_valid & ~bus.upd_ready);
            if (init_req) begin
                state_q     <= S_INIT;
                walk_q      <= '0;
                w_valid_q   <= 1'b0;
                fwd_valid_q <= 1'b0;
            end else begin
                if (!run) begin
                    walk_q <= walk_q + PHT_DEPTH'(1);
                    if (&walk_q) state_q <= S_RUN;
                end
                w_valid_q   <= pop;
                w_idx_q     <= h_idx;
                w_taken_q   <= h_taken;
                fwd_valid_q <= run & w_valid_q;
                fwd_idx_q   <= w_idx_q;
                fwd_data_q  <= upd_val;
            end
        end
endmodule
